// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W and ACK bit encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchroniser, optional glitch filter (I2C_SLAVE_GLITCH_FILTER_EN), edge/START/STOP detect.
// Latency: SYNC_STAGES+1 clk to an edge strobe, plus GLITCH_CYC clk when the filter is built in.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_p_q;
    logic                   sda_p_q;

    // Synchronise both lines; reset to the idle (pulled-up) level.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = $clog2(GLITCH_CYC + 1);

    logic [1:0]         raw;
    logic [1:0]         filt_q;
    logic [1:0][CW-1:0] cnt_q;

    assign raw = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

    // Accept a new line level only after GLITCH_CYC consecutive differing samples.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            filt_q <= '1;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(GLITCH_CYC - 1)) begin
                    filt_q[i] <= raw[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f = filt_q[1];
    assign sda_f = filt_q[0];
`else
    logic unused_glitch_cyc;
    assign unused_glitch_cyc = ^GLITCH_CYC;
    assign scl_f = scl_sync_q[SYNC_STAGES-1];
    assign sda_f = sda_sync_q[SYNC_STAGES-1];
`endif

    // Previous conditioned sample for edge and condition detection.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_p_q <= scl_f;
            sda_p_q <= sda_f;
        end
    end

    // Conditions need SCL high in both samples; an SDA move across an SCL edge is data.
    assign scl_rise  = scl_f & ~scl_p_q;
    assign scl_fall  = ~scl_f & scl_p_q;
    assign start_det = scl_f & scl_p_q & sda_p_q & ~sda_f;
    assign stop_det  = scl_f & scl_p_q & ~sda_p_q & sda_f;
    assign sda_s     = sda_f;

endmodule

// File: rtl/i2c_slave.sv
// I2C target at SLV_ADDR: write bytes out on rx_valid, read bytes from tx_data (filter: I2C_SLAVE_GLITCH_FILTER_EN).
// Latency: SDA driven on the clk after a detected SCL fall; rx_valid 1 clk after the 8th data rise.
// Backpressure: none; tx_data must be valid whenever tx_req pulses, rx_valid is not held.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         GLITCH_CYC  = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_seen
);

    logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, shift_in;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       nack_q, nack_d;

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES),
        .GLITCH_CYC (GLITCH_CYC)
    ) u_line_cond (
        .clk      (clk),
        .rstn     (rstn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );

    assign shift_in = {shift_q[6:0], sda_s};

    // Protocol FSM: bus conditions first, then SCL edges; SDA only moves after a fall.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        nack_d     = 1'b0;
        tx_req     = 1'b0;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shift_in[7:1] == SLV_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = shift_in[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b1;
                    if (rw_q == I2C_RW_READ) begin
                        tx_req  = 1'b1;
                        shift_d = tx_data;
                    end
                end else if (scl_rise) begin
                    state_d = (rw_q == I2C_RW_READ) ? RD_DATA : WR_DATA;
                end
                WR_DATA: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                end else if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b1;
                end else if (scl_rise) begin
                    state_d = WR_DATA;
                end
                RD_DATA: if (scl_fall) begin
                    sda_oe_d = ~shift_q[7];
                end else if (scl_rise) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RD_ACK;
                    end
                end
                RD_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                end else if (scl_rise) begin
                    if (sda_s == I2C_ACK) begin
                        tx_req  = 1'b1;
                        shift_d = tx_data;
                        state_d = RD_DATA;
                    end else begin
                        nack_d  = 1'b1;
                        state_d = IGNORE;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rw_q       <= I2C_RW_WRITE;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign nack_seen = nack_q;

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Bus-side I2C target that consumes the traffic produced by i2c_master on the shared open-drain scl/sda pair.
- Oversamples the bus on the 100 MHz system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, delivers write bytes on a valid-strobe output, and serves read bytes from a local data input.
- Sits on the same pulled-up bus as the master in the system bench and is the master's transaction sink.

Parameters:
- SLV_ADDR, 7'h50, 7-bit target address.
- SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i (min 2).
- GLITCH_CYC, 3, consecutive equal samples required to accept a line change (filter build only).

Ports:
- clk  in  1  system clock, 100 MHz.
- rstn  in  1  reset, asynchronous, active-high.
- scl_i  in  1  bus SCL sense.
- sda_i  in  1  bus SDA sense.
- sda_oe  out  1  1 = pull SDA low; top level ties sda to 0 when set, else Z.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  in  8  byte returned on the next read; sampled on tx_req.
- tx_req  out  1  one-cycle strobe; tx_data is latched in the same cycle.
- busy  out  1  high from an address match to STOP.
- nack_seen  out  1  one-cycle strobe when the master NACKs a read byte.

Behaviour:
- Reset (rstn=1): sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, nack_seen=0, state=IDLE, all counters cleared. Reset is asynchronous and takes effect immediately, including mid-byte; the slave then releases SDA.
- Line path: SYNC_STAGES flops per line. Edge detect uses the last two synced samples, so detection latency is SYNC_STAGES+1 clk.
- START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both are recognised in every state. START always goes to ADDR with bit count 0. STOP always goes to IDLE and clears busy and sda_oe.
- Sampling and driving: SDA is sampled on the SCL rising edge. sda_oe changes only on the clock after an SCL falling edge is detected, never while SCL=1.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W).
    - Match: go to ADDR_ACK and set busy.
    - Mismatch: go to IGNORE; sda_oe stays 0.
  - ADDR_ACK: drive sda_oe=1 for one SCL period.
    - R/W=1: pulse tx_req as ACK is asserted, latch tx_data into the shift register, go to RD_DATA.
    - R/W=0: go to WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th SCL rising edge, load rx_data and pulse rx_valid one cycle later. Then WR_ACK.
  - WR_ACK: drive sda_oe=1 for one SCL period, then WR_DATA. Writes are unbounded.
  - RD_DATA: after each SCL falling edge, sda_oe = ~shift[7]; shift left on each rising edge. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on the SCL rising edge.
    - 0 (ACK): pulse tx_req, latch tx_data, return to RD_DATA.
    - 1 (NACK): pulse nack_seen, go to IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary.
- Simultaneous events: START/STOP detection takes priority over SCL-edge processing in the same clk.
- An SCL rising edge seen while SDA is changing counts as a data sample, not a condition, because conditions require SCL stable high.
- Timing assumption: SCL high/low ≥ 4 clk after filtering. Shorter pulses give undefined data but must not lock up; the next START or STOP recovers.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchroniser, each line passes a saturating counter filter. The filtered value changes only after GLITCH_CYC consecutive equal samples, adding GLITCH_CYC clk of latency. Pulses shorter than GLITCH_CYC clk are rejected.
- Undefined: the synchroniser output feeds edge detect directly, and the GLITCH_CYC parameter is unused.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - I2C_RW_READ=1 / I2C_RW_WRITE=0;
  - I2C_ACK=0 / I2C_NACK=1.
  The package is shared with i2c_master.
- Sub-module i2c_line_cond holds the synchroniser, the optional glitch filter and edge/START/STOP detect. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s. One instance of it is also reusable inside i2c_master.

Test Plan:
- Write 1 byte: master sends START, 0xA0 (0x50,W), 0x5A, STOP -> sda_oe low in both ACK slots, one rx_valid with rx_data=0x5A, busy high from address ACK to STOP, then low.
- Address mismatch: START, 0xB4, 0x5A, STOP -> sda_oe never asserted, no rx_valid, busy stays 0, state back to IDLE after STOP.
- Read 2 bytes: tx_data=0xC3 then 0x3C; master sends START, 0xA1, ACK byte 1, NACK byte 2, STOP -> SDA carries 0xC3 then 0x3C, two tx_req pulses, one nack_seen, sda_oe=0 after the NACK.
- Repeated START: START, 0xA0, 0x11, Sr, 0xA1, read 1 byte with NACK, STOP -> rx_data=0x11, then a read of tx_data with no STOP in between; busy stays high through Sr.
- Reset mid-byte: assert rstn during bit 4 of a read while sda_oe=1 -> sda_oe=0 in the same clk; after release, the next full START/write transaction completes normally.
- Glitch (I2C_SLAVE_GLITCH_FILTER_EN defined, GLITCH_CYC=3): inject a 2-clk SCL low pulse mid-bit -> no extra bit counted and rx_data is correct. Same stimulus without the macro -> a bit-count corruption is observed, confirming the filter is active only when the macro is defined.
